decode_buffer: RTL and testbench
================================

DECODE_BUFFER -- requirements
Module: decode_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered entries; a power of two, 2..16.
REQ-002 Parameter PTR_W, default $clog2(DEPTH), pointer width; derived, not overridden.
REQ-003 Ports below (name  direction  width  meaning). The block has one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  fetch offers an instruction.
REQ-007 in_ready  out  1  buffer accepts; equals !full.
REQ-008 in_inst  in  32  instruction word.
REQ-009 in_pc  in  32  instruction address.
REQ-010 flush  in  1  discard all entries and delay-slot state.
REQ-011 out_valid  out  1  head entry present.
REQ-012 out_ready  in  1  ID consumes head.
REQ-013 out_inst, out_pc  out  32 each  head instruction and address.
REQ-014 out_ctrl  out  12  predecoded head flags: {bd, branch, load, store, mdu, cp0r, cp0w, eret, syscall, brk, ri, regwen}.
REQ-015 out_wreg  out  5  head destination register; 0 when regwen is 0.
REQ-016 count  out  PTR_W+1  occupancy.

Function
REQ-017 Enqueue occurs when in_valid && in_ready && !flush; the entry stores inst, pc, predecoded flags, wreg, and bd.
REQ-018 Dequeue occurs when out_valid && out_ready && !flush.
REQ-019 Predecoding is combinational on in_inst at enqueue, classifying MIPS32 I/R/J instructions.
  - branch covers J, JAL, JR, JALR, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL.
  - regwen is 1 for ALU, load, MFHI/MFLO, MFC0, and link instructions.
  - wreg is rd for R-type, 31 for link instructions, and rt otherwise.
  - ri is 1 for every unlisted encoding; ri forces regwen to 0.
REQ-020 The bd flag of an entry is the registered branch flag of the previously enqueued instruction.
  - The tracker updates only on enqueue, so gaps between enqueues do not lose the delay-slot association.
REQ-021 in_ready does not consider a same-cycle dequeue: when full, no enqueue occurs even if out_ready is 1.
REQ-022 Simultaneous enqueue and dequeue at 0 < count < DEPTH leaves count unchanged.
REQ-023 Pointers wrap modulo DEPTH; full is count == DEPTH and empty is count == 0.
REQ-024 Flush takes priority: the next cycle has count = 0, out_valid = 0, and the bd tracker cleared; same-cycle enqueue and dequeue are ignored.
REQ-025 Outputs are taken from the head register; latency from enqueue to out_valid is 1 cycle (see REQ-030 for the bypass variant).
REQ-026 Head outputs hold stable while out_valid && !out_ready.

Reset
REQ-027 Asserting resetn low immediately clears pointers, count, and the bd tracker, and drives out_valid = 0 and in_ready = 0.
REQ-028 in_ready rises in the first cycle after reset deassertion.
REQ-029 Payload storage is not reset; out_inst, out_pc, out_ctrl, and out_wreg are don't-care while out_valid = 0.
  - The bench still checks that these outputs are 0 after reset when DBUF_BYPASS_EN is undefined; the implementation zeroes the head register.

Configuration
REQ-030 With DBUF_BYPASS_EN defined, an enqueue into an empty buffer appears on the outputs in the same cycle.
  - out_valid = in_valid && in_ready && !flush, with combinational out_inst, out_pc, out_ctrl, and out_wreg.
  - If out_ready is also 1, the entry is not stored.
REQ-031 Without DBUF_BYPASS_EN, latency is exactly 1 cycle with no combinational path from in_* to out_*.

Structure
REQ-032 Opcode, funct, and rt-branch constants and the ctrl bit indices belong in the shared package cpu_pkg, reused by the ID stage.
REQ-033 Predecoding is the sub-module inst_predecode (purely combinational); the decode_buffer holds all sequential logic.

Verification
REQ-034 Fill test: DEPTH=4, four enqueues with out_ready=0 -> count=4, in_ready=0; a fifth in_valid is not accepted.
REQ-035 Delay-slot test: enqueue BEQ (0x10220003) then ADDU (0x00431021) -> the second entry has bd=1, branch=0, and wreg=2.
REQ-036 Flush test: count=3, flush with in_valid=1 -> next cycle count=0, out_valid=0, and the following enqueue has bd=0.
REQ-037 Reserved-instruction test: enqueue 0xFC000000 -> ri=1, regwen=0, wreg=0.
REQ-038 Wrap test: 20 enqueues and dequeues with random backpressure -> output order matches input pc, with no loss or duplication.
REQ-039 Reset test: drop resetn mid-stream at count=2 -> out_valid=0 immediately; after release, count=0 and in_ready=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared MIPS32 encoding constants, predecode flag indices and the decode buffer entry type.
// Reused by the ID stage so both agree on opcode values and ctrl bit positions.
package cpu_pkg;

    localparam int CTRL_W       = 12;
    localparam int PD_W         = CTRL_W - 1;
    localparam int CTRL_REGWEN  = 0;
    localparam int CTRL_RI      = 1;
    localparam int CTRL_BRK     = 2;
    localparam int CTRL_SYSCALL = 3;
    localparam int CTRL_ERET    = 4;
    localparam int CTRL_CP0W    = 5;
    localparam int CTRL_CP0R    = 6;
    localparam int CTRL_MDU     = 7;
    localparam int CTRL_STORE   = 8;
    localparam int CTRL_LOAD    = 9;
    localparam int CTRL_BRANCH  = 10;
    localparam int CTRL_BD      = 11;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_BREAK   = 6'h0D;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;
    localparam logic [5:0] FN_ERET    = 6'h18;

    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;
    localparam logic [4:0] RS_MF      = 5'h00;
    localparam logic [4:0] RS_MT      = 5'h04;

    typedef struct packed {
        logic [31:0]       inst;
        logic [31:0]       pc;
        logic [CTRL_W-1:0] ctrl;
        logic [4:0]        wreg;
    } dbuf_entry_t;

endpackage

// File: rtl/inst_predecode.sv
// Purely combinational MIPS32 predecoder: classifies an instruction word into ctrl flags
// (all except bd) and its destination register.
module inst_predecode
    import cpu_pkg::*;
(
    input  logic [31:0]     inst,
    output logic [PD_W-1:0] ctrl,
    output logic [4:0]      wreg
);

    logic [5:0]      op_s;
    logic [5:0]      fn_s;
    logic [4:0]      rs_s;
    logic [4:0]      rt_s;
    logic [4:0]      rd_s;
    logic [4:0]      dst_s;
    logic [PD_W-1:0] ctrl_s;

    assign op_s = inst[31:26];
    assign fn_s = inst[5:0];
    assign rs_s = inst[25:21];
    assign rt_s = inst[20:16];
    assign rd_s = inst[15:11];

    // Classify opcode/funct/rt/rs into flags and choose the destination field.
    always_comb begin
        ctrl_s = '0;
        dst_s  = rt_s;
        case (op_s)
            OP_SPECIAL: begin
                dst_s = rd_s;
                case (fn_s)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU:
                        ctrl_s[CTRL_REGWEN] = 1'b1;
                    FN_JR:      ctrl_s[CTRL_BRANCH] = 1'b1;
                    FN_JALR: begin
                        ctrl_s[CTRL_BRANCH] = 1'b1;
                        ctrl_s[CTRL_REGWEN] = 1'b1;
                    end
                    FN_SYSCALL: ctrl_s[CTRL_SYSCALL] = 1'b1;
                    FN_BREAK:   ctrl_s[CTRL_BRK]     = 1'b1;
                    FN_MFHI, FN_MFLO: begin
                        ctrl_s[CTRL_MDU]    = 1'b1;
                        ctrl_s[CTRL_REGWEN] = 1'b1;
                    end
                    FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
                        ctrl_s[CTRL_MDU] = 1'b1;
                    default:    ctrl_s[CTRL_RI] = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                case (rt_s)
                    RT_BLTZ, RT_BGEZ: ctrl_s[CTRL_BRANCH] = 1'b1;
                    RT_BLTZAL, RT_BGEZAL: begin
                        ctrl_s[CTRL_BRANCH] = 1'b1;
                        ctrl_s[CTRL_REGWEN] = 1'b1;
                        dst_s               = 5'd31;
                    end
                    default: ctrl_s[CTRL_RI] = 1'b1;
                endcase
            end
            OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                ctrl_s[CTRL_BRANCH] = 1'b1;
            OP_JAL: begin
                ctrl_s[CTRL_BRANCH] = 1'b1;
                ctrl_s[CTRL_REGWEN] = 1'b1;
                dst_s               = 5'd31;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                ctrl_s[CTRL_REGWEN] = 1'b1;
            OP_COP0: begin
                if (rs_s == RS_MF) begin
                    ctrl_s[CTRL_CP0R]   = 1'b1;
                    ctrl_s[CTRL_REGWEN] = 1'b1;
                end else if (rs_s == RS_MT) begin
                    ctrl_s[CTRL_CP0W] = 1'b1;
                end else if (inst[25] && (fn_s == FN_ERET)) begin
                    ctrl_s[CTRL_ERET] = 1'b1;
                end else begin
                    ctrl_s[CTRL_RI] = 1'b1;
                end
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                ctrl_s[CTRL_LOAD]   = 1'b1;
                ctrl_s[CTRL_REGWEN] = 1'b1;
            end
            OP_SB, OP_SH, OP_SW:
                ctrl_s[CTRL_STORE] = 1'b1;
            default: ctrl_s[CTRL_RI] = 1'b1;
        endcase
    end

    assign ctrl = ctrl_s;
    assign wreg = ctrl_s[CTRL_REGWEN] ? dst_s : 5'd0;

endmodule

// File: rtl/decode_buffer.sv
// Instruction buffer between fetch and ID with predecode and branch-delay-slot tagging.
// Optional feature macro DBUF_BYPASS_EN: an enqueue into an empty buffer is visible the same cycle.
module decode_buffer
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [31:0]       in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [4:0]        out_wreg,
    output logic [PTR_W:0]    count
);

    dbuf_entry_t      mem_r [DEPTH];
    dbuf_entry_t      head_r;
    dbuf_entry_t      head_next_s;
    dbuf_entry_t      new_s;
    dbuf_entry_t      sel_s;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] rd_ptr_inc_s;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_next_s;
    logic             bd_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             out_valid_s;
    logic [PD_W-1:0]  pd_ctrl_s;
    logic [4:0]       pd_wreg_s;
    logic             enq_s;
    logic             deq_s;
    logic             take_s;
    logic             store_s;
    logic             pop_s;

    inst_predecode u_predecode (
        .inst (in_inst),
        .ctrl (pd_ctrl_s),
        .wreg (pd_wreg_s)
    );

    assign new_s.inst = in_inst;
    assign new_s.pc   = in_pc;
    assign new_s.ctrl = {bd_r, pd_ctrl_s};
    assign new_s.wreg = pd_wreg_s;

    assign enq_s = in_valid && in_ready_r && !flush;

`ifdef DBUF_BYPASS_EN
    // An entry shown straight from the input and consumed the same cycle never touches storage.
    assign out_valid_s = out_valid_r || (enq_s && (count_r == '0));
    assign take_s      = enq_s && (count_r == '0) && out_ready;
    assign sel_s       = out_valid_r ? head_r : new_s;
`else
    assign out_valid_s = out_valid_r;
    assign take_s      = 1'b0;
    assign sel_s       = head_r;
`endif

    assign deq_s        = out_valid_s && out_ready && !flush;
    assign store_s      = enq_s && !take_s;
    assign pop_s        = deq_s && !take_s;
    assign rd_ptr_inc_s = rd_ptr_r + PTR_W'(1);

    // Next occupancy; flush wins over any same-cycle transfer.
    always_comb begin
        count_next_s = count_r;
        if (flush) begin
            count_next_s = '0;
        end else begin
            count_next_s = count_r + (PTR_W+1)'(store_s) - (PTR_W+1)'(pop_s);
        end
    end

    // Next head: the incoming entry when it lands in an empty slot, else the next stored entry.
    always_comb begin
        head_next_s = head_r;
        if (!flush && store_s && ((count_r == '0) || (pop_s && (count_r == (PTR_W+1)'(1))))) begin
            head_next_s = new_s;
        end else if (!flush && pop_s && (count_r > (PTR_W+1)'(1))) begin
            head_next_s = mem_r[rd_ptr_inc_s];
        end else begin
            head_next_s = head_r;
        end
    end

    // Payload storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (store_s) begin
            mem_r[wr_ptr_r] <= new_s;
        end
    end

    // Pointers, occupancy, registered handshakes, head register and delay-slot tracker.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            bd_r        <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            head_r      <= '0;
        end else begin
            count_r     <= count_next_s;
            in_ready_r  <= (count_next_s != (PTR_W+1)'(DEPTH));
            out_valid_r <= (count_next_s != '0);
            head_r      <= head_next_s;
            if (flush) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                bd_r     <= 1'b0;
            end else begin
                if (store_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_inc_s;
                end
                if (enq_s) begin
                    bd_r <= pd_ctrl_s[CTRL_BRANCH];
                end
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_s;
    assign out_inst  = sel_s.inst;
    assign out_pc    = sel_s.pc;
    assign out_ctrl  = sel_s.ctrl;
    assign out_wreg  = sel_s.wreg;
    assign count     = count_r;

endmodule

// File: tb/tb_decode_buffer.sv
// Randomized and directed bench for decode_buffer (default build) against a queue-based reference model.
module tb_decode_buffer;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [11:0] out_ctrl;
    logic [4:0]  out_wreg;
    logic [2:0]  count;

    always #5 clk = ~clk;

    decode_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_ctrl  (out_ctrl),
        .out_wreg  (out_wreg),
        .count     (count)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [11:0] ctrl;
        logic [4:0]  wreg;
    } exp_t;

    exp_t        q[$];
    bit          bd_m;
    bit          rdy_m;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] pc_ctr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference classification written as instruction-set membership rules.
    function automatic void ref_decode(input logic [31:0] w, output logic [11:0] c, output logic [4:0] d);
        int op, fn, rs, rt, rd;
        bit r_alu, hilo_rd, hilo_wr, jr, jalr, sys, brk, rb, rl, j, jal, bc, i_alu;
        bit mfc0, mtc0, eret, ld, st, branch, ri, regwen;
        op = int'(w[31:26]); fn = int'(w[5:0]); rs = int'(w[25:21]);
        rt = int'(w[20:16]); rd = int'(w[15:11]);
        r_alu   = (op == 0) && (fn inside {0, 2, 3, 4, 6, 7, [32:39], 42, 43});
        hilo_rd = (op == 0) && (fn inside {16, 18});
        hilo_wr = (op == 0) && (fn inside {17, 19, [24:27]});
        jr      = (op == 0) && (fn == 8);
        jalr    = (op == 0) && (fn == 9);
        sys     = (op == 0) && (fn == 12);
        brk     = (op == 0) && (fn == 13);
        rb      = (op == 1) && (rt inside {0, 1});
        rl      = (op == 1) && (rt inside {16, 17});
        j       = (op == 2);
        jal     = (op == 3);
        bc      = (op inside {[4:7]});
        i_alu   = (op inside {[8:15]});
        mfc0    = (op == 16) && (rs == 0);
        mtc0    = (op == 16) && (rs == 4);
        eret    = (op == 16) && w[25] && (fn == 24);
        ld      = (op inside {32, 33, 35, 36, 37});
        st      = (op inside {40, 41, 43});
        branch  = jr | jalr | rb | rl | j | jal | bc;
        ri      = !(r_alu | hilo_rd | hilo_wr | jr | jalr | sys | brk | rb | rl | j | jal |
                    bc | i_alu | mfc0 | mtc0 | eret | ld | st);
        regwen  = !ri && (r_alu | hilo_rd | jalr | rl | jal | i_alu | mfc0 | ld);
        c = {1'b0, branch, ld, st, hilo_rd | hilo_wr, mfc0, mtc0, eret, sys, brk, ri, regwen};
        if (!regwen)         d = 5'd0;
        else if (op == 0)    d = 5'(rd);
        else if (jal || rl)  d = 5'd31;
        else                 d = 5'(rt);
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [5:0]  op_tab [16];
        logic [5:0]  fn_tab [12];
        logic [4:0]  rt_tab [5];
        logic [4:0]  rs_tab [3];
        op_tab = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h09,
                   6'h0F, 6'h10, 6'h23, 6'h24, 6'h2B, 6'h28, 6'h3F, 6'h1C};
        fn_tab = '{6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h10, 6'h13, 6'h1A,
                   6'h21, 6'h27, 6'h2B, 6'h3E};
        rt_tab = '{5'h00, 5'h01, 5'h10, 5'h11, 5'h05};
        rs_tab = '{5'h00, 5'h04, 5'h10};
        w = $urandom;
        if ($urandom_range(0, 9) < 8) begin
            w[31:26] = op_tab[$urandom_range(0, 15)];
            if (w[31:26] == 6'h00) w[5:0]   = fn_tab[$urandom_range(0, 11)];
            if (w[31:26] == 6'h01) w[20:16] = rt_tab[$urandom_range(0, 4)];
            if (w[31:26] == 6'h10) begin
                w[25:21] = rs_tab[$urandom_range(0, 2)];
                if (w[25:21] == 5'h10) w[5:0] = 6'h18;
            end
        end
        return w;
    endfunction

    task automatic compare();
        chk("count", 64'(count), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(rdy_m));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_inst", 64'(out_inst), 64'(q[0].inst));
            chk("out_pc", 64'(out_pc), 64'(q[0].pc));
            chk("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
            chk("out_wreg", 64'(out_wreg), 64'(q[0].wreg));
        end
    endtask

    // One clock: apply the model's transfer rules to the inputs held across the edge, then compare.
    task automatic step();
        exp_t        e;
        logic [11:0] c;
        logic [4:0]  d;
        bit          enq, deq;
        @(posedge clk);
        if (!resetn) begin
            q.delete(); bd_m = 1'b0; rdy_m = 1'b0;
        end else begin
            enq = in_valid && rdy_m && !flush;
            deq = (q.size() > 0) && out_ready && !flush;
            if (flush) begin
                q.delete(); bd_m = 1'b0;
            end else begin
                if (deq) void'(q.pop_front());
                if (enq) begin
                    ref_decode(in_inst, c, d);
                    c[11] = bd_m;
                    e = '{in_inst, in_pc, c, d};
                    q.push_back(e);
                    bd_m = c[10];
                end
            end
            rdy_m = (q.size() != DEPTH);
        end
        #1;
        compare();
    endtask

    task automatic send(input logic [31:0] w);
        in_valid = 1'b1; in_inst = w; in_pc = pc_ctr; pc_ctr = pc_ctr + 32'd4;
        step();
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
        flush = 1'b0; out_ready = 1'b0; pc_ctr = 32'h0000_1000;
        bd_m = 1'b0; rdy_m = 1'b0;
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_out_wreg", 64'(out_wreg), 64'd0);
        step(); step();
        resetn = 1'b1;
        step();
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // Fill to DEPTH, then offer a fifth while draining one.
        for (int i = 0; i < 4; i++) send(rand_inst());
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        send(rand_inst());
        chk("fifth_rejected", 64'(count), 64'd3);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Delay slot: ADDU behind BEQ carries bd.
        out_ready = 1'b0;
        send(32'h1022_0003);
        send(32'h0043_1021);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("ds_bd", 64'(out_ctrl[11]), 64'd1);
        chk("ds_branch", 64'(out_ctrl[10]), 64'd0);
        chk("ds_wreg", 64'(out_wreg), 64'd2);
        step();

        // Flush at count 3 with a branch last enqueued and in_valid high.
        out_ready = 1'b0;
        send(32'h0043_1021); send(32'h0043_1021); send(32'h0800_0000);
        in_valid = 1'b1; in_inst = 32'h1022_0003; in_pc = pc_ctr; flush = 1'b1;
        step();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        send(32'h0043_1021);
        chk("flush_bd", 64'(out_ctrl[11]), 64'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();

        // Reserved instruction.
        out_ready = 1'b0;
        send(32'hFC00_0000);
        in_valid = 1'b0;
        chk("ri_flag", 64'(out_ctrl[1]), 64'd1);
        chk("ri_regwen", 64'(out_ctrl[0]), 64'd0);
        chk("ri_wreg", 64'(out_wreg), 64'd0);
        out_ready = 1'b1;
        step();

        // Random traffic with backpressure and rare flushes; pointers wrap many times.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            in_inst   = rand_inst();
            in_pc     = pc_ctr;
            pc_ctr    = pc_ctr + 32'd4;
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // Asynchronous reset with two entries held.
        out_ready = 1'b0;
        send(rand_inst()); send(rand_inst());
        in_valid = 1'b0;
        chk("pre_rst_count", 64'(count), 64'd2);
        #2 resetn = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd0);
        chk("async_count", 64'(count), 64'd0);
        step();
        resetn = 1'b1;
        step();
        chk("rel_count", 64'(count), 64'd0);
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
